// File: rtl/adc_sar_fifo_ctrl_pkg.sv
// Shared definitions for the SAR ADC capture controller: widths, FSM encoding, bit-mask helper.
package adc_sar_fifo_ctrl_pkg;

    localparam int unsigned ADC_BITS  = 10;
    localparam int unsigned CLKDIV_W  = 20;
    localparam int unsigned BIT_IDX_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    localparam logic [1:0] S_PUSH  = 2'd3;

    typedef logic [ADC_BITS-1:0] sample_t;

    // One-hot trial bit for SAR position idx
    function automatic sample_t bit_mask(input logic [BIT_IDX_W-1:0] idx);
        return sample_t'(1) << idx;
    endfunction

endpackage

// File: rtl/adc_sar_fifo_ctrl_if.sv
// Control, macro and sample-FIFO signals of the SAR ADC controller; slave = controller side.
interface adc_sar_fifo_ctrl_if
    import adc_sar_fifo_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_AW = 5
);
    logic                EN;
    logic                clk_en;
    logic [CLKDIV_W-1:0] clkdiv;
    logic [FIFO_AW-1:0]  fifo_threshold;
    logic                rd;
    logic                ovr_clr;
    logic                CMP;
    logic                HOLD;
    sample_t             DAC_CODE;
    sample_t             data;
    logic                empty;
    logic                full;
    logic [FIFO_AW:0]    level;
    logic                high;
    logic                overrun;

    modport master (
        output EN, clk_en, clkdiv, fifo_threshold, rd, ovr_clr, CMP,
        input  HOLD, DAC_CODE, data, empty, full, level, high, overrun
    );

    modport slave (
        input  EN, clk_en, clkdiv, fifo_threshold, rd, ovr_clr, CMP,
        output HOLD, DAC_CODE, data, empty, full, level, high, overrun
    );

endinterface

// File: rtl/adc_sar_fifo_ctrl_fifo.sv
// First-word fall-through sample FIFO; writes when full and reads when empty are ignored.
module adc_sample_fifo #(
    parameter int unsigned DW = 10,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_wr, do_rd;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rp_q];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (do_wr) begin
            mem_d[wp_q] = wdata;
            wp_d        = wp_q + AW'(1);
        end
        if (do_rd) begin
            rp_d = rp_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
        end
    end

    // Sample storage needs no reset: it is only read behind a non-zero level
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/adc_sar_fifo_ctrl.sv
// SAR ADC controller: sample-rate divider, track/hold + 10-bit SAR FSM, result FIFO with flags.
module adc_sar_fifo_ctrl
    import adc_sar_fifo_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_AW    = 5,
    parameter int unsigned SAMPLE_CYC = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_sar_fifo_ctrl_if.slave  bus
);
    localparam int unsigned LVL_W  = FIFO_AW + 1;
    localparam int unsigned PH_MAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    logic [CLKDIV_W-1:0]  div_q, div_d;
    logic                 tick_q, tick_d;
    logic [1:0]           state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [BIT_IDX_W-1:0] bit_q, bit_d;
    sample_t              result_q, result_d;
    logic                 hold_q, hold_d;
    sample_t              dac_q, dac_d;
    logic                 overrun_q, overrun_d;
    logic                 wr_c;

    sample_t              fifo_data;
    logic                 fifo_empty, fifo_full;
    logic [LVL_W-1:0]     fifo_level;

    // Sample-rate divider; tick is registered one cycle after the wrap
    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        if (bus.EN && bus.clk_en) begin
            if (div_q == bus.clkdiv) begin
                div_d  = '0;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + CLKDIV_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        bit_d    = bit_q;
        result_d = result_q;
        hold_d   = hold_q;
        dac_d    = dac_q;
        wr_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    state_d = S_TRACK;
                    hold_d  = 1'b1;
                    ph_d    = '0;
                end
            end
            S_TRACK: begin
                if (ph_q == PH_W'(SAMPLE_CYC - 1)) begin
                    state_d  = S_CONV;
                    hold_d   = 1'b0;
                    ph_d     = '0;
                    bit_d    = BIT_IDX_W'(ADC_BITS - 1);
                    result_d = '0;
                    dac_d    = bit_mask(BIT_IDX_W'(ADC_BITS - 1));
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_CONV: begin
                // The current trial code already carries the bit under test
                if (ph_q == PH_W'(SETTLE_CYC - 1)) begin
                    ph_d = '0;
                    if (bus.CMP) begin
                        result_d = dac_q;
                    end
                    if (bit_q == '0) begin
                        state_d = S_PUSH;
                        dac_d   = result_d;
                    end else begin
                        bit_d = bit_q - BIT_IDX_W'(1);
                        dac_d = result_d | bit_mask(bit_d);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            S_PUSH: begin
                wr_c    = 1'b1;
                state_d = S_IDLE;
                dac_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Disable aborts from any state without touching the FIFO
        if (!bus.EN) begin
            state_d = S_IDLE;
            hold_d  = 1'b0;
            dac_d   = '0;
            wr_c    = 1'b0;
        end
        overrun_d = overrun_q;
        if (wr_c && fifo_full) begin
            overrun_d = 1'b1;
        end else if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            result_q  <= '0;
            hold_q    <= 1'b0;
            dac_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            result_q  <= result_d;
            hold_q    <= hold_d;
            dac_q     <= dac_d;
            overrun_q <= overrun_d;
        end
    end

    adc_sample_fifo #(
        .DW (ADC_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr_c),
        .wdata (result_q),
        .rd    (bus.rd),
        .rdata (fifo_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign bus.HOLD     = hold_q;
    assign bus.DAC_CODE = dac_q;
    assign bus.overrun  = overrun_q;
    assign bus.data     = fifo_data;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.level    = fifo_level;
    assign bus.high     = (fifo_level >= {1'b0, bus.fifo_threshold});

endmodule

// File: tb/tb_adc_sar_fifo_ctrl.sv
// Directed bench for adc_sar_fifo_ctrl with a behavioural comparator model driving CMP.
module tb_adc_sar_fifo_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] vin   = 10'h000;
    int         n_checks = 0;
    int         n_err    = 0;
    int         n;
    logic [9:0] trial [10];

    adc_sar_fifo_ctrl_if #(.FIFO_AW(5)) bus ();

    adc_sar_fifo_ctrl #(
        .FIFO_AW    (5),
        .SAMPLE_CYC (4),
        .SETTLE_CYC (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.CMP = (vin >= bus.DAC_CODE);

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_level(input int lv, input int limit, input string tag);
        int k = 0;
        while (32'(bus.level) != 32'(lv) && k < limit) begin
            step(1);
            k++;
        end
        chk(tag, 32'(bus.level), 32'(lv));
    endtask

    task automatic wait_hold(input int limit, input string tag);
        int k = 0;
        while (!bus.HOLD && k < limit) begin
            step(1);
            k++;
        end
        chk(tag, 32'(bus.HOLD), 32'd1);
    endtask

    task automatic pop();
        bus.rd = 1'b1;
        step(1);
        bus.rd = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        trial = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                  10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};
        bus.EN             = 1'b1;
        bus.clk_en         = 1'b1;
        bus.clkdiv         = 20'd99;
        bus.fifo_threshold = 5'd0;
        bus.rd             = 1'b0;
        bus.ovr_clr        = 1'b0;
        vin                = 10'h2A5;

        // Reset values and threshold boundary
        #12;
        chk("rst_hold",    32'(bus.HOLD),     32'd0);
        chk("rst_dac",     32'(bus.DAC_CODE), 32'd0);
        chk("rst_empty",   32'(bus.empty),    32'd1);
        chk("rst_full",    32'(bus.full),     32'd0);
        chk("rst_level",   32'(bus.level),    32'd0);
        chk("rst_overrun", 32'(bus.overrun),  32'd0);
        chk("thr0_high",   32'(bus.high),     32'd1);
        bus.fifo_threshold = 5'd4;
        #1;
        chk("thr4_high_l0", 32'(bus.high), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // 1: single conversion of 0x2A5, trial sequence and latency
        wait_hold(200, "t1_hold_rise");
        n = 0;
        while (bus.HOLD && n < 20) begin
            n++;
            step(1);
        end
        chk("t1_hold_cycles", 32'(n), 32'd4);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t1_dac_trial%0d", i), 32'(bus.DAC_CODE), 32'(trial[i]));
            step(1);
        end
        chk("t1_empty_during_push", 32'(bus.empty), 32'd1);
        step(1);
        chk("t1_empty_after_15", 32'(bus.empty),    32'd0);
        chk("t1_data",           32'(bus.data),     32'h2A5);
        chk("t1_level",          32'(bus.level),    32'd1);
        chk("t1_hold_idle",      32'(bus.HOLD),     32'd0);
        chk("t1_dac_idle",       32'(bus.DAC_CODE), 32'd0);
        pop();
        chk("t1_empty_pop", 32'(bus.empty), 32'd1);

        // 2: all-keep and all-clear boundaries
        vin = 10'h3FF;
        wait_level(1, 300, "t2_level1");
        chk("t2_data_3ff", 32'(bus.data), 32'h3FF);
        vin = 10'h000;
        wait_level(2, 300, "t2_level2");
        chk("t2_head_kept", 32'(bus.data), 32'h3FF);
        pop();
        chk("t2_data_000", 32'(bus.data),  32'h000);
        chk("t2_level_1",  32'(bus.level), 32'd1);
        pop();
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // 3: fill to full with distinct samples, then overrun
        bus.clkdiv = 20'd0;
        vin        = 10'h100;
        pulse_reset();
        for (int k = 1; k <= 32; k++) begin
            wait_level(k, 40, $sformatf("t3_fill%0d", k));
            vin = 10'(32'h100 + 32'(k));
        end
        chk("t3_full",      32'(bus.full),    32'd1);
        chk("t3_no_ovr",    32'(bus.overrun), 32'd0);
        chk("t3_high",      32'(bus.high),    32'd1);
        n = 0;
        while (!bus.overrun && n < 40) begin
            step(1);
            n++;
        end
        chk("t3_overrun",   32'(bus.overrun), 32'd1);
        chk("t3_level32",   32'(bus.level),   32'd32);
        chk("t3_head_kept", 32'(bus.data),    32'h100);
        chk("t3_full_kept", 32'(bus.full),    32'd1);
        bus.ovr_clr = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);

        // 4: rd during PUSH on a full FIFO still drops the result
        step(14);
        bus.rd = 1'b1;
        step(1);
        bus.EN = 1'b0;
        chk("t4_level31", 32'(bus.level),   32'd31);
        chk("t4_overrun", 32'(bus.overrun), 32'd1);
        for (int j = 1; j <= 31; j++) begin
            chk($sformatf("t4_drain%0d", j), 32'(bus.data), 32'h100 + 32'(j));
            step(1);
        end
        bus.rd = 1'b0;
        chk("t4_empty",        32'(bus.empty),   32'd1);
        chk("t4_ovr_retained", 32'(bus.overrun), 32'd1);
        bus.ovr_clr = 1'b1;
        step(1);
        bus.ovr_clr = 1'b0;

        // 5: abort mid-CONV, then a clean conversion
        bus.clkdiv = 20'd9;
        vin        = 10'h2A5;
        bus.EN     = 1'b1;
        wait_hold(50, "t5_hold_rise");
        step(7);
        chk("t5_dac_mid", 32'(bus.DAC_CODE), 32'h2C0);
        bus.EN = 1'b0;
        step(1);
        chk("t5_abort_hold", 32'(bus.HOLD),     32'd0);
        chk("t5_abort_dac",  32'(bus.DAC_CODE), 32'd0);
        step(20);
        chk("t5_no_write", 32'(bus.level), 32'd0);
        bus.EN = 1'b1;
        vin    = 10'h0F0;
        wait_level(1, 60, "t5_reconv");
        chk("t5_data", 32'(bus.data), 32'h0F0);
        pop();

        // 6: high watermark at threshold 4, then async reset mid-conversion
        wait_level(3, 120, "t6_level3");
        chk("t6_high_l3", 32'(bus.high), 32'd0);
        wait_level(4, 60, "t6_level4");
        chk("t6_high_l4", 32'(bus.high), 32'd1);
        wait_hold(60, "t6_hold_rise");
        step(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_hold",    32'(bus.HOLD),     32'd0);
        chk("t6_rst_dac",     32'(bus.DAC_CODE), 32'd0);
        chk("t6_rst_level",   32'(bus.level),    32'd0);
        chk("t6_rst_empty",   32'(bus.empty),    32'd1);
        chk("t6_rst_full",    32'(bus.full),     32'd0);
        chk("t6_rst_overrun", 32'(bus.overrun),  32'd0);
        rst_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
